// File: rtl/lif_update_sequencer_pkg.sv
// rtl/lif_update_sequencer_pkg.sv - shared widths, FSM state encoding and saturation helpers
package lif_update_sequencer_pkg;

  localparam int LANES  = 8;
  localparam int POT_W  = 16;
  localparam int BETA_W = 8;
  localparam int ADDR_W = 9;

  localparam logic signed [POT_W-1:0] SAT_MAX = 16'sh7FFF;
  localparam logic signed [POT_W-1:0] SAT_MIN = 16'sh8000;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE    = 3'd0;
  localparam state_t ST_ISSUE   = 3'd1;
  localparam state_t ST_WAIT    = 3'd2;
  localparam state_t ST_COMPUTE = 3'd3;
  localparam state_t ST_WRITE   = 3'd4;

  function automatic logic signed [17:0] sext18(input logic [POT_W-1:0] v);
    return {{2{v[POT_W-1]}}, v};
  endfunction

  // An 18-bit value fits 16 bits only when its top three bits agree.
  function automatic logic signed [POT_W-1:0] sat16(input logic signed [17:0] v);
    if (v[17:15] == 3'b000 || v[17:15] == 3'b111) begin
      return v[POT_W-1:0];
    end
    return v[17] ? SAT_MIN : SAT_MAX;
  endfunction

endpackage

// File: rtl/lif_update_sequencer_if.sv
// rtl/lif_update_sequencer_if.sv - current stream, SRAM ports and spike output bundle
interface lif_update_sequencer_if;
  import lif_update_sequencer_pkg::*;

  logic [LANES*POT_W-1:0]  cur_in;
  logic                    cur_valid;
  logic                    cur_ready;
  logic [ADDR_W-1:0]       cntrl_potential_read_addr;
  logic [ADDR_W-1:0]       cntrl_beta_read_addr;
  logic [LANES*POT_W-1:0]  potential_read_out;
  logic [LANES*BETA_W-1:0] beta_read_out;
  logic [ADDR_W-1:0]       cntrl_potential_write_addr;
  logic [LANES*POT_W-1:0]  potential_write_in;
  logic                    cntrl_potential_write_we;
  logic [LANES-1:0]        spike_out;
  logic                    spike_valid;
  logic [ADDR_W-1:0]       spike_row;

  modport master (
    input  cur_in, cur_valid, potential_read_out, beta_read_out,
    output cur_ready, cntrl_potential_read_addr, cntrl_beta_read_addr,
           cntrl_potential_write_addr, potential_write_in, cntrl_potential_write_we,
           spike_out, spike_valid, spike_row
  );

  modport slave (
    output cur_in, cur_valid, potential_read_out, beta_read_out,
    input  cur_ready, cntrl_potential_read_addr, cntrl_beta_read_addr,
           cntrl_potential_write_addr, potential_write_in, cntrl_potential_write_we,
           spike_out, spike_valid, spike_row
  );

endinterface

// File: rtl/lif_update_sequencer_lif_lane.sv
// rtl/lif_update_sequencer_lif_lane.sv - one neuron: decay, add current, saturate, fire, reset
// LIF_SOFT_RESET_EN: fired lanes keep sat16(u' - threshold) instead of clearing to 0.
module lif_lane
  import lif_update_sequencer_pkg::*;
(
  input  logic signed [POT_W-1:0] u,
  input  logic [BETA_W-1:0]       beta,
  input  logic signed [POT_W-1:0] cur,
  input  logic signed [POT_W-1:0] threshold,
  output logic [POT_W-1:0]        u_next,
  output logic                    spike
);

  logic signed [23:0]      u_ext;
  logic signed [23:0]      beta_ext;
  logic signed [23:0]      product;
  logic signed [POT_W-1:0] decay;
  logic signed [POT_W-1:0] u_sat;

  assign u_ext    = $signed({{8{u[POT_W-1]}}, u});
  assign beta_ext = $signed({16'b0, beta});
  // |u * beta| < 2^23, so the 24-bit product is exact and the shifted value fits 16 bits.
  assign product  = u_ext * beta_ext;
  assign decay    = POT_W'(product >>> 8);
  assign u_sat    = sat16(sext18(decay) + sext18(cur));
  assign spike    = (u_sat >= threshold);

`ifdef LIF_SOFT_RESET_EN
  assign u_next = spike ? sat16(sext18(u_sat) - sext18(threshold)) : u_sat;
`else
  assign u_next = spike ? '0 : u_sat;
`endif

endmodule

// File: rtl/lif_update_sequencer.sv
// rtl/lif_update_sequencer.sv - sweeps potential rows, applies LIF update per lane, writes back
// Soft-reset variant selected by LIF_SOFT_RESET_EN inside lif_lane; ports unchanged.
module lif_update_sequencer
  import lif_update_sequencer_pkg::*;
#(
  parameter int NUM_ROWS = 512
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [POT_W-1:0]      threshold,
  lif_update_sequencer_if.master bus,
  output logic                  busy,
  output logic                  done
);

  localparam logic [ADDR_W-1:0] LAST_ROW = ADDR_W'(NUM_ROWS - 1);

  state_t                  state;
  logic [ADDR_W-1:0]       row;
  logic [ADDR_W-1:0]       rd_addr;
  logic [ADDR_W-1:0]       wr_addr;
  logic signed [POT_W-1:0] thr_q;
  logic                    fetch;
  logic [LANES*POT_W-1:0]  pot_q;
  logic [LANES*BETA_W-1:0] beta_q;
  logic [LANES*POT_W-1:0]  cur_q;
  logic [LANES*POT_W-1:0]  wr_data;
  logic [LANES-1:0]        spk_q;
  logic                    done_q;
  logic [LANES*POT_W-1:0]  lane_next;
  logic [LANES-1:0]        lane_spike;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    lif_lane u_lane (
      .u         (pot_q[i*POT_W +: POT_W]),
      .beta      (beta_q[i*BETA_W +: BETA_W]),
      .cur       (cur_q[i*POT_W +: POT_W]),
      .threshold (thr_q),
      .u_next    (lane_next[i*POT_W +: POT_W]),
      .spike     (lane_spike[i])
    );
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_IDLE;
      row     <= '0;
      rd_addr <= '0;
      wr_addr <= '0;
      thr_q   <= '0;
      fetch   <= 1'b0;
      pot_q   <= '0;
      beta_q  <= '0;
      cur_q   <= '0;
      wr_data <= '0;
      spk_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            state   <= ST_ISSUE;
            row     <= '0;
            rd_addr <= '0;
            thr_q   <= threshold;
          end
        end
        ST_ISSUE: begin
          fetch <= 1'b1;
          state <= ST_WAIT;
        end
        ST_WAIT: begin
          // SRAM data is valid only in the first WAIT cycle; later cycles may stall on current.
          if (fetch) begin
            pot_q  <= bus.potential_read_out;
            beta_q <= bus.beta_read_out;
            fetch  <= 1'b0;
          end
          if (bus.cur_valid) begin
            cur_q <= bus.cur_in;
            state <= ST_COMPUTE;
          end
        end
        ST_COMPUTE: begin
          wr_data <= lane_next;
          spk_q   <= lane_spike;
          wr_addr <= row;
          state   <= ST_WRITE;
        end
        ST_WRITE: begin
          if (row == LAST_ROW) begin
            state  <= ST_IDLE;
            done_q <= 1'b1;
          end else begin
            row     <= row + ADDR_W'(1);
            rd_addr <= row + ADDR_W'(1);
            state   <= ST_ISSUE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign busy = (state != ST_IDLE);
  assign done = done_q;

  assign bus.cur_ready                  = (state == ST_WAIT);
  assign bus.cntrl_potential_read_addr  = rd_addr;
  assign bus.cntrl_beta_read_addr       = rd_addr;
  assign bus.cntrl_potential_write_addr = wr_addr;
  assign bus.potential_write_in         = wr_data;
  assign bus.cntrl_potential_write_we   = (state == ST_WRITE);
  assign bus.spike_out                  = spk_q;
  assign bus.spike_valid                = (state == ST_WRITE);
  assign bus.spike_row                  = wr_addr;

endmodule

// File: tb/tb_lif_update_sequencer.sv
// tb/tb_lif_update_sequencer.sv - directed and random sweeps against an integer LIF model
// LIF_SOFT_RESET_EN selects the soft-reset expectation.
module tb_lif_update_sequencer;
  import lif_update_sequencer_pkg::*;

  typedef struct {
    logic [8:0]   addr;
    logic [127:0] data;
    logic [7:0]   spk;
    logic [8:0]   row;
    logic         sv;
  } wr_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        start_a, start_b;
  logic [15:0] thr_a, thr_b;
  logic        busy_a, done_a, busy_b, done_b;

  int checks = 0;
  int errors = 0;
  int done_cnt_a = 0;
  int done_cnt_b = 0;
  wr_t wq_a[$];
  wr_t wq_b[$];

  logic [127:0] pot_a  [2];
  logic [63:0]  beta_a [2];
  logic [127:0] pot_b  [512];
  logic [63:0]  beta_b [512];

  always #5 clk = ~clk;

  lif_update_sequencer_if bus_a ();
  lif_update_sequencer_if bus_b ();

  lif_update_sequencer #(.NUM_ROWS(2)) dut_a (
    .clk(clk), .reset(reset), .start(start_a), .threshold(thr_a),
    .bus(bus_a), .busy(busy_a), .done(done_a)
  );

  lif_update_sequencer #(.NUM_ROWS(512)) dut_b (
    .clk(clk), .reset(reset), .start(start_b), .threshold(thr_b),
    .bus(bus_b), .busy(busy_b), .done(done_b)
  );

  always @(posedge clk) begin
    bus_a.potential_read_out <= pot_a[bus_a.cntrl_potential_read_addr[0]];
    bus_a.beta_read_out      <= beta_a[bus_a.cntrl_beta_read_addr[0]];
    bus_b.potential_read_out <= pot_b[bus_b.cntrl_potential_read_addr];
    bus_b.beta_read_out      <= beta_b[bus_b.cntrl_beta_read_addr];
  end

  always @(negedge clk) begin
    if (bus_a.cntrl_potential_write_we)
      wq_a.push_back('{bus_a.cntrl_potential_write_addr, bus_a.potential_write_in,
                       bus_a.spike_out, bus_a.spike_row, bus_a.spike_valid});
    if (bus_b.cntrl_potential_write_we)
      wq_b.push_back('{bus_b.cntrl_potential_write_addr, bus_b.potential_write_in,
                       bus_b.spike_out, bus_b.spike_row, bus_b.spike_valid});
    if (done_a) done_cnt_a++;
    if (done_b) done_cnt_b++;
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int clamp16(input int v);
    return (v > 32767) ? 32767 : ((v < -32768) ? -32768 : v);
  endfunction

  // Floor-divide by 256, add current, clamp, fire, reset: the neuron rule in plain integers.
  function automatic void row_model(input logic [127:0] pot, input logic [63:0] beta,
                                    input logic [127:0] cur, input logic [15:0] thr,
                                    output logic [127:0] nx, output logic [7:0] sp);
    nx = '0;
    sp = '0;
    for (int i = 0; i < 8; i++) begin
      int u, b, c, t, p, d, s, r;
      u = int'($signed(pot[16*i +: 16]));
      b = int'(beta[8*i +: 8]);
      c = int'($signed(cur[16*i +: 16]));
      t = int'($signed(thr));
      p = u * b;
      d = p / 256;
      if (p < 0 && (p % 256) != 0) d = d - 1;
      s = clamp16(d + c);
      sp[i] = (s >= t);
`ifdef LIF_SOFT_RESET_EN
      r = sp[i] ? clamp16(s - t) : s;
`else
      r = sp[i] ? 0 : s;
`endif
      nx[16*i +: 16] = r[15:0];
    end
  endfunction

  task automatic sweep_a(input string tag, input int hold,
                         input logic [127:0] cur, input logic [15:0] thr);
    logic [127:0] ed [2];
    logic [7:0]   es [2];
    int n, base, got;
    for (int r = 0; r < 2; r++) row_model(pot_a[r], beta_a[r], cur, thr, ed[r], es[r]);
    wq_a.delete();
    base = done_cnt_a;
    bus_a.cur_in = cur;
    bus_a.cur_valid = (hold == 0);
    thr_a = thr;
    @(negedge clk) start_a = 1'b1;
    @(posedge clk);
    #1 start_a = 1'b0;
    n = 0;
    got = 0;
    while (got == 0 && n < 300) begin
      @(posedge clk);
      #1;
      n++;
      if (n <= hold) begin
        chk({tag, "_hold_ready"}, bus_a.cur_ready, 1);
        chk({tag, "_hold_no_we"}, bus_a.cntrl_potential_write_we, 0);
        chk({tag, "_hold_busy"}, busy_a, 1);
      end
      if (n == hold + 1) bus_a.cur_valid = 1'b1;
      if (done_a) got = 1;
    end
    chk({tag, "_done_seen"}, got, 1);
    chk({tag, "_latency"}, n, 8 + hold);
    chk({tag, "_busy_at_done"}, busy_a, 0);
    @(posedge clk);
    #1;
    chk({tag, "_done_pulse"}, done_a, 0);
    chk({tag, "_done_count"}, done_cnt_a - base, 1);
    chk({tag, "_writes"}, wq_a.size(), 2);
    for (int r = 0; r < wq_a.size() && r < 2; r++) begin
      chk({tag, "_waddr"}, wq_a[r].addr, r);
      chk({tag, "_srow"}, wq_a[r].row, r);
      chk({tag, "_svalid"}, wq_a[r].sv, 1);
      chk({tag, "_wdata"}, wq_a[r].data, ed[r]);
      chk({tag, "_spike"}, wq_a[r].spk, es[r]);
    end
    bus_a.cur_valid = 1'b0;
  endtask

  task automatic wait_write_b(input int row_idx, output int found);
    int n;
    n = 0;
    found = 0;
    while (found == 0 && n < 60) begin
      @(posedge clk);
      #1;
      n++;
      if (bus_b.cntrl_potential_write_we && bus_b.cntrl_potential_write_addr == 9'(row_idx))
        found = 1;
    end
  endtask

  initial begin
    logic [127:0] cur_b;
    logic [127:0] exp_b [512];
    logic [7:0]   exps_b [512];
    int n, got, base, tmp;

    reset = 1'b1;
    start_a = 1'b0;
    start_b = 1'b0;
    thr_a = '0;
    thr_b = '0;
    bus_a.cur_in = '0;
    bus_a.cur_valid = 1'b0;
    bus_b.cur_in = '0;
    bus_b.cur_valid = 1'b0;
    for (int r = 0; r < 2; r++) begin
      pot_a[r] = '0;
      beta_a[r] = '0;
    end
    for (int r = 0; r < 512; r++) begin
      pot_b[r] = '0;
      beta_b[r] = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy_a, 0);
    chk("rst_done", done_a, 0);
    chk("rst_we", bus_a.cntrl_potential_write_we, 0);
    chk("rst_spike_valid", bus_a.spike_valid, 0);
    chk("rst_spike_out", bus_a.spike_out, 0);
    chk("rst_cur_ready", bus_a.cur_ready, 0);
    chk("rst_rd_addr", bus_a.cntrl_potential_read_addr, 0);
    chk("rst_beta_addr", bus_a.cntrl_beta_read_addr, 0);
    chk("rst_wr_addr", bus_a.cntrl_potential_write_addr, 0);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Plain decay with no spike.
    for (int r = 0; r < 2; r++) begin
      pot_a[r] = {8{16'h0100}};
      beta_a[r] = {8{8'h80}};
    end
    sweep_a("basic", 0, {8{16'h0010}}, 16'h1000);
    if (wq_a.size() == 2) chk("basic_const", wq_a[1].data, {8{16'h0090}});

    // Stall on the current handshake; results must not change.
    sweep_a("stall", 5, {8{16'h0010}}, 16'h1000);
    if (wq_a.size() == 2) chk("stall_const", wq_a[0].data, {8{16'h0090}});

    // Positive saturation and firing.
    for (int r = 0; r < 2; r++) begin
      pot_a[r] = {8{16'h7F00}};
      beta_a[r] = {8{8'hFF}};
    end
    sweep_a("satpos", 0, {8{16'h7FFF}}, 16'h1000);
    if (wq_a.size() == 2) begin
      chk("satpos_spike_const", wq_a[0].spk, 8'hFF);
`ifdef LIF_SOFT_RESET_EN
      chk("satpos_data_const", wq_a[0].data, {8{16'h6FFF}});
`else
      chk("satpos_data_const", wq_a[0].data, 128'h0);
`endif
    end

    // Negative saturation; row 1 exercises floor rounding of a small negative product.
    pot_a[0] = {8{16'h8000}};
    beta_a[0] = {8{8'hFF}};
    pot_a[1] = {8{16'hFF01}};
    beta_a[1] = {8{8'h01}};
    sweep_a("satneg", 0, {8{16'h8000}}, 16'h1000);
    if (wq_a.size() == 2) begin
      chk("satneg_data_const", wq_a[0].data, {8{16'h8000}});
      chk("satneg_spike_const", wq_a[0].spk, 8'h00);
    end
    pot_a[1] = {8{16'hFF01}};
    beta_a[1] = {8{8'h01}};
    sweep_a("negshift", 0, 128'h0, 16'h1000);
    if (wq_a.size() == 2) chk("negshift_const", wq_a[1].data, {8{16'hFFFF}});

    for (int k = 0; k < 6; k++) begin
      for (int r = 0; r < 2; r++) begin
        pot_a[r] = {$urandom, $urandom, $urandom, $urandom};
        beta_a[r] = {$urandom, $urandom};
      end
      tmp = int'($urandom_range(0, 8000)) - 4000;
      sweep_a("rand", int'($urandom_range(0, 3)),
              {$urandom, $urandom, $urandom, $urandom}, tmp[15:0]);
    end

    // Instance B: start while busy is ignored, then reset lands during the WRITE of row 3.
    for (int r = 0; r < 512; r++) begin
      pot_b[r] = {$urandom, $urandom, $urandom, $urandom};
      beta_b[r] = {$urandom, $urandom};
    end
    bus_b.cur_in = {$urandom, $urandom, $urandom, $urandom};
    bus_b.cur_valid = 1'b1;
    thr_b = 16'h0800;
    wq_b.delete();
    @(negedge clk) start_b = 1'b1;
    @(posedge clk);
    #1 start_b = 1'b0;
    wait_write_b(1, got);
    chk("mid_row1_seen", got, 1);
    start_b = 1'b1;
    @(posedge clk);
    #1 start_b = 1'b0;
    chk("mid_busy", busy_b, 1);
    wait_write_b(3, got);
    chk("mid_row3_seen", got, 1);
    base = done_cnt_b;
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("abort_we", bus_b.cntrl_potential_write_we, 0);
    chk("abort_spike_valid", bus_b.spike_valid, 0);
    chk("abort_busy", busy_b, 0);
    chk("abort_done", done_b, 0);
    chk("abort_cur_ready", bus_b.cur_ready, 0);
    chk("abort_rd_addr", bus_b.cntrl_potential_read_addr, 0);
    chk("abort_wr_addr", bus_b.cntrl_potential_write_addr, 0);
    chk("abort_spike_out", bus_b.spike_out, 0);
    reset = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    chk("abort_no_done", done_cnt_b - base, 0);
    chk("abort_idle", busy_b, 0);
    chk("abort_writes", wq_b.size(), 4);
    for (int r = 0; r < wq_b.size() && r < 4; r++)
      chk("abort_order", wq_b[r].addr, r);

    // Full 512-row sweep.
    for (int r = 0; r < 512; r++) begin
      pot_b[r] = {$urandom, $urandom, $urandom, $urandom};
      beta_b[r] = {$urandom, $urandom};
    end
    cur_b = {$urandom, $urandom, $urandom, $urandom};
    bus_b.cur_in = cur_b;
    thr_b = 16'h0400;
    for (int r = 0; r < 512; r++) row_model(pot_b[r], beta_b[r], cur_b, thr_b, exp_b[r], exps_b[r]);
    wq_b.delete();
    base = done_cnt_b;
    @(negedge clk) start_b = 1'b1;
    @(posedge clk);
    #1 start_b = 1'b0;
    n = 0;
    got = 0;
    while (got == 0 && n < 2200) begin
      @(posedge clk);
      #1;
      n++;
      if (done_b) got = 1;
    end
    chk("full_done_seen", got, 1);
    chk("full_latency", n, 2048);
    repeat (3) @(posedge clk);
    #1;
    chk("full_done_count", done_cnt_b - base, 1);
    chk("full_writes", wq_b.size(), 512);
    for (int r = 0; r < wq_b.size() && r < 512; r++) begin
      chk("full_addr", wq_b[r].addr, r);
      chk("full_data", wq_b[r].data, exp_b[r]);
      chk("full_spike", wq_b[r].spk, exps_b[r]);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
